sprite_row_streamer: RTL and testbench
======================================

Name: sprite_row_streamer

Overview:
Consumes the registered sprite ROM (8-bit word address, 16-bit data, one-cycle registered read) and turns one 64-pixel sprite row into a serial 1-bit pixel stream for the reel pixel mux.
On a start request it fetches the row's 4 ROM words into a 64-bit line buffer. It then streams the pixels over a valid/ready handshake, with optional horizontal flip and integer horizontal scaling.
One instance per reel ROM instance.

Parameters:
SCALE, 1, beats per pixel (horizontal replication); legal 1..4
ROM_LATENCY, 2, rising edges from rom_addr register update to rom_data capture (1 ROM output register + 1 address register)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to stream a row; honoured only when busy=0
row  in  6  sprite row index 0..63, sampled with start
h_flip  in  1  mirror row, sampled with start
busy  out  1  high from the edge that accepts start until the edge that completes the last beat
rom_addr  out  8  registered word address to the sprite ROM
rom_data  in  16  ROM word, valid ROM_LATENCY edges after the matching rom_addr update
pix_valid  out  1  pix_data/pix_last are valid
pix_ready  in  1  downstream accepts the beat when pix_valid&pix_ready
pix_data  out  1  pixel bit (1 = sprite foreground)
pix_last  out  1  marks the final beat of the row

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0; rom_addr=0; pix_valid=0; pix_data=0; pix_last=0.
  - Line buffer, counters and capture pipeline cleared.
- Memory layout:
  - Row r occupies words 4r..4r+3; word 0 holds pixels 0..15.
  - Pixel 0 is the MSB of word 0; pixel 63 is the LSB of word 3.
- States: IDLE, FETCH, DRAIN, STREAM.
- IDLE:
  - On start, at edge E0: rom_addr<=row*4 (6-bit row concatenated with 2'b00); latch h_flip; busy<=1; go to FETCH.
- FETCH:
  - rom_addr increments at E1, E2, E3, so it holds 4r, 4r+1, 4r+2, 4r+3 after E0..E3.
  - A 2-deep valid pipeline (widx tagged) tracks the outstanding reads.
  - After the address 4r+3 is issued, go to DRAIN.
- Capture:
  - rom_data for the word issued at edge Ek is written into line buffer slot k at edge Ek+2, i.e. E2..E5.
- DRAIN:
  - Wait for the last capture (E5), then go to STREAM with pix_valid=1 from E5.
  - First pix_valid is high 5 edges after the start-accepting edge.
- STREAM:
  - Pixel index p counts 0..63; a replicate counter counts 0..SCALE-1.
  - pix_data = buffer pixel p, or pixel 63-p when the latched h_flip=1.
  - Advance only on pix_valid&pix_ready; p increments when the replicate counter wraps.
  - pix_last=1 only on beat (63, SCALE-1).
  - Outputs are registered and held stable while pix_valid=1 and pix_ready=0.
  - After the last handshake: pix_valid=0, pix_last=0, busy=0, state=IDLE, all in the same edge. A start in the following cycle is accepted.
- start while busy=1 is ignored, with no queuing.
- rom_addr holds its last value outside FETCH.
- Total beats per row = 64*SCALE. With pix_ready tied high, busy lasts exactly 5+64*SCALE cycles.
- Reset asserted mid-FETCH or mid-STREAM aborts immediately to the reset values. The in-flight ROM data is discarded.
- Row 63 gives rom_addr 252..255; there is no wrap into row 0.

Decomposition:
- Shared package sprite_pkg: SPRITE_W=64, SPRITE_H=64, ROM_WORD_W=16, WORDS_PER_ROW=4, ROM_ADDR_W=8, and the state enum typedef stream_state_t.
- One natural sub-module, sprite_row_buffer: 4x16 line buffer with indexed write and flip-aware 6-bit pixel read.
- FSM, address generator and handshake logic stay in the top.

Test Plan:
- ROM words 8..11 = 8001,FFFF,0000,A5A5; start row=2, h_flip=0, SCALE=1, pix_ready=1:
  - rom_addr sequence is 8,9,10,11.
  - 64 beats: 1, fourteen 0s, 1, sixteen 1s, sixteen 0s, then 1010010110100101.
  - pix_last only on beat 64; busy low after 69 cycles.
- Same data, h_flip=1: first beats are 1010010110100101, followed by sixteen 0s, sixteen 1s, then 1, fourteen 0s, 1.
- SCALE=2, row=2: 128 beats, each pixel doubled (first four beats 1,1,0,0); pix_last on beat 128.
- Backpressure: pix_ready toggled 1,0,0,1 repeatedly.
  - pix_data/pix_last stay stable while stalled; no beat is lost or duplicated.
  - Stream matches the first scenario.
- start pulsed mid-STREAM with row=5: ignored; rom_addr does not change from 11 and the stream completes unchanged.
  - A start in the cycle after pix_last handshake with row=63 is accepted: rom_addr 252..255.
- reset_n pulsed low at beat 20: all outputs go to 0 immediately.
  - After release a fresh start row=2 reproduces the full first-scenario stream from beat 1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite geometry, FSM state encoding and capture-tag bundle
// used by the sprite row streamer and its line buffer.
package sprite_pkg;

    localparam int SPRITE_W      = 64;
    localparam int SPRITE_H      = 64;
    localparam int ROM_WORD_W    = 16;
    localparam int WORDS_PER_ROW = 4;
    localparam int ROM_ADDR_W    = 8;
    localparam int PIX_IDX_W     = 6;
    localparam int WIDX_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_STREAM
    } stream_state_t;

    typedef struct packed {
        logic              valid;
        logic [WIDX_W-1:0] widx;
    } cap_tag_t;

    // 63-p is the bitwise complement for a 6-bit index
    function automatic logic [PIX_IDX_W-1:0] pix_index(
        input logic [PIX_IDX_W-1:0] p,
        input logic                 flip
    );
        return flip ? ~p : p;
    endfunction

endpackage

// File: rtl/sprite_row_buffer.sv
// 4x16 sprite line buffer: word-indexed write, flip-aware pixel read.
// Pixel 0 is the MSB of word 0, pixel 63 the LSB of word 3.
module sprite_row_buffer
    import sprite_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_we,
    input  logic [WIDX_W-1:0]     i_widx,
    input  logic [ROM_WORD_W-1:0] i_wdata,
    input  logic [PIX_IDX_W-1:0]  i_pix,
    input  logic                  i_flip,
    output logic                  o_pix
);

    logic [ROM_WORD_W-1:0] r_words [WORDS_PER_ROW];
    logic [PIX_IDX_W-1:0]  w_idx;
    logic [ROM_WORD_W-1:0] w_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
                r_words[i] <= '0;
            end
        end else if (i_we) begin
            r_words[i_widx] <= i_wdata;
        end
    end

    always_comb begin
        w_idx  = pix_index(i_pix, i_flip);
        w_word = r_words[w_idx[5:4]];
        o_pix  = w_word[~w_idx[3:0]];
    end

endmodule

// File: rtl/sprite_row_streamer.sv
// Fetches one 64-pixel sprite row from the registered ROM into a line
// buffer and streams it as 1-bit beats with optional flip and scaling.
module sprite_row_streamer
    import sprite_pkg::*;
#(
    parameter int SCALE       = 1,
    parameter int ROM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [5:0]            row,
    input  logic                  h_flip,
    output logic                  busy,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [ROM_WORD_W-1:0] rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic                  pix_last
);

    localparam logic [1:0]           REP_MAX   = 2'(SCALE - 1);
    localparam logic [PIX_IDX_W-1:0] PIX_MAX   = PIX_IDX_W'(SPRITE_W - 1);
    localparam logic [WIDX_W-1:0]    WIDX_LAST = WIDX_W'(WORDS_PER_ROW - 1);
    localparam logic [WIDX_W-1:0]    WIDX_PEN  = WIDX_W'(WORDS_PER_ROW - 2);

    stream_state_t r_state;
    stream_state_t w_state_nxt;

    logic [ROM_ADDR_W-1:0] r_rom_addr;
    logic [WIDX_W-1:0]     r_widx;
    logic                  r_flip;
    cap_tag_t              r_pipe [ROM_LATENCY];
    logic [PIX_IDX_W-1:0]  r_pix;
    logic [1:0]            r_rep;
    logic                  r_valid;
    logic                  r_last;

    logic                  w_issue_first;
    logic                  w_issue_next;
    logic                  w_cap;
    logic                  w_cap_last;
    logic                  w_stream_go;
    logic                  w_fire;
    logic                  w_rep_wrap;
    logic                  w_row_done;
    logic [1:0]            w_rep_nxt;
    logic [PIX_IDX_W-1:0]  w_pix_nxt;
    logic                  w_buf_pix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (r_widx == WIDX_PEN) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_cap_last) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (w_row_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue_first = (r_state == ST_IDLE) && start;
        w_issue_next  = (r_state == ST_FETCH);
        w_cap         = r_pipe[ROM_LATENCY-1].valid;
        w_cap_last    = w_cap && (r_pipe[ROM_LATENCY-1].widx == WIDX_LAST);
        w_stream_go   = (r_state == ST_DRAIN) && w_cap_last;
        w_fire        = r_valid && pix_ready;
        w_rep_wrap    = (r_rep == REP_MAX);
        w_row_done    = w_fire && w_rep_wrap && (r_pix == PIX_MAX);
        w_rep_nxt     = w_rep_wrap ? 2'd0 : r_rep + 2'd1;
        w_pix_nxt     = w_rep_wrap ? r_pix + 6'd1 : r_pix;
        busy          = (r_state != ST_IDLE);
    end

    // Address generation and read-tag pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr <= '0;
            r_widx     <= '0;
            r_flip     <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (w_issue_first) begin
                r_rom_addr <= {row, 2'b00};
                r_widx     <= '0;
                r_flip     <= h_flip;
            end else if (w_issue_next) begin
                r_rom_addr <= r_rom_addr + 8'd1;
                r_widx     <= r_widx + 2'd1;
            end
            r_pipe[0].valid <= w_issue_first || w_issue_next;
            r_pipe[0].widx  <= w_issue_first ? '0 : r_widx + 2'd1;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Beat sequencing; outputs only move on a handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pix   <= '0;
            r_rep   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_stream_go) begin
            r_pix   <= '0;
            r_rep   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (w_fire) begin
            r_pix <= w_pix_nxt;
            r_rep <= w_rep_nxt;
            if (w_row_done) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_last <= (w_pix_nxt == PIX_MAX) && (w_rep_nxt == REP_MAX);
            end
        end
    end

    sprite_row_buffer u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_cap),
        .i_widx  (r_pipe[ROM_LATENCY-1].widx),
        .i_wdata (rom_data),
        .i_pix   (r_pix),
        .i_flip  (r_flip),
        .o_pix   (w_buf_pix)
    );

    assign rom_addr  = r_rom_addr;
    assign pix_valid = r_valid;
    assign pix_last  = r_last;
    assign pix_data  = r_valid & w_buf_pix;

endmodule

// File: tb/tb_sprite_row_streamer.sv
// Scoreboard bench for sprite_row_streamer: SCALE=1 and SCALE=2 instances
// share one registered ROM model; a negedge monitor checks every beat.
module tb_sprite_row_streamer;

    localparam logic [63:0] L0  = 64'h8001_FFFF_0000_A5A5;
    localparam logic [63:0] LF  = 64'hA5A5_0000_FFFF_8001;
    localparam logic [63:0] L63 = 64'h1234_5678_9ABC_DEF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start1, flip1, ready1, busy1, valid1, data1, last1;
    logic [5:0]  row1;
    logic [7:0]  rom_addr1;
    logic [15:0] rom_data1;
    logic        start2, flip2, ready2, busy2, valid2, data2, last2;
    logic [5:0]  row2;
    logic [7:0]  rom_addr2;
    logic [15:0] rom_data2;

    logic [15:0] mem [256];

    int n_chk = 0;
    int n_pass = 0;
    int beats1 = 0;
    bit bp_en = 0;
    bit [1:0] q1[$];
    bit [1:0] q2[$];

    sprite_row_streamer #(.SCALE(1), .ROM_LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start1), .row(row1),
        .h_flip(flip1), .busy(busy1), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .pix_valid(valid1), .pix_ready(ready1),
        .pix_data(data1), .pix_last(last1)
    );

    sprite_row_streamer #(.SCALE(2), .ROM_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .row(row2),
        .h_flip(flip2), .busy(busy2), .rom_addr(rom_addr2),
        .rom_data(rom_data2), .pix_valid(valid2), .pix_ready(ready2),
        .pix_data(data2), .pix_last(last2)
    );

    always @(posedge clk) begin
        rom_data1 <= mem[rom_addr1];
        rom_data2 <= mem[rom_addr2];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic push_exp(input bit sel, input logic [63:0] lit,
                            input int sc);
        bit [1:0] b;
        for (int i = 0; i < 64 * sc; i++) begin
            b = {lit[63 - i / sc], (i == 64 * sc - 1)};
            if (sel) q2.push_back(b);
            else q1.push_back(b);
        end
    endtask

    // Monitor: pops one expected beat per handshake, checks stall hold
    initial begin
        bit [1:0] e;
        bit held;
        bit pd, pl;
        held = 0; pd = 0; pl = 0;
        forever begin
            @(negedge clk);
            if (held && valid1) begin
                chk("hold_data", data1, pd);
                chk("hold_last", last1, pl);
            end
            held = valid1 && !ready1;
            pd = data1;
            pl = last1;
            if (valid1 && ready1) begin
                if (q1.size() == 0) chk("beat1_extra", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk($sformatf("beat1_%0d", beats1), {data1, last1}, e);
                end
                beats1++;
            end
            if (valid2 && ready2) begin
                if (q2.size() == 0) chk("beat2_extra", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("beat2", {data2, last2}, e);
                end
            end
        end
    end

    // Backpressure pattern 1,0,0,1 when enabled
    initial begin
        bit [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                ready1 = pat[3 - k];
                k = (k + 1) % 4;
            end else begin
                ready1 = 1'b1;
            end
        end
    end

    task automatic run_row(input bit sel, input logic [5:0] r, input bit f,
                           input logic [63:0] lit, input int sc,
                           input int exp_cyc, input int poke);
        int n;
        logic b;
        logic [7:0] a;
        logic [7:0] base;
        base = {r, 2'b00};
        if (sel) begin start2 = 1; row2 = r; flip2 = f; end
        else begin start1 = 1; row1 = r; flip1 = f; end
        push_exp(sel, lit, sc);
        @(posedge clk);
        #1;
        start1 = 0;
        start2 = 0;
        n = 0;
        b = sel ? busy2 : busy1;
        chk("busy_rise", b, 1);
        do begin
            a = sel ? rom_addr2 : rom_addr1;
            chk("rom_addr", a, base + 8'(n < 3 ? n : 3));
            start1 = (!sel && poke > 0 && n == poke);
            if (start1) begin row1 = 6'd5; flip1 = 1; end
            @(posedge clk);
            #1;
            n++;
            b = sel ? busy2 : busy1;
        end while (b && n < 2000);
        start1 = 0;
        chk("busy_timeout", n < 2000, 1);
        if (exp_cyc > 0) chk("busy_cycles", n, exp_cyc);
        chk("valid_idle", sel ? valid2 : valid1, 0);
        chk("queue_drained", sel ? q2.size() : q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        reset_n = 0;
        start1 = 0; row1 = 0; flip1 = 0; ready1 = 1;
        start2 = 0; row2 = 0; flip2 = 0; ready2 = 1;
        for (int i = 0; i < 256; i++) mem[i] = 16'h5A3C ^ 16'(i);
        mem[8] = 16'h8001; mem[9] = 16'hFFFF;
        mem[10] = 16'h0000; mem[11] = 16'hA5A5;
        for (int i = 20; i < 24; i++) mem[i] = 16'hFFFF;
        mem[252] = 16'h1234; mem[253] = 16'h5678;
        mem[254] = 16'h9ABC; mem[255] = 16'hDEF0;

        #12;
        chk("rst_busy", busy1, 0);
        chk("rst_addr", rom_addr1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_data", data1, 0);
        chk("rst_last", last1, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk);
        #1;

        run_row(0, 6'd2, 0, L0, 1, 69, 0);
        run_row(0, 6'd2, 1, LF, 1, 69, 0);
        run_row(1, 6'd2, 0, L0, 2, 133, 0);
        bp_en = 1;
        run_row(0, 6'd2, 0, L0, 1, 0, 0);
        bp_en = 0;
        @(posedge clk);
        #2;
        run_row(0, 6'd2, 0, L0, 1, 69, 30);
        run_row(0, 6'd63, 0, L63, 1, 69, 0);

        base = beats1;
        start1 = 1; row1 = 6'd2; flip1 = 0;
        push_exp(0, L0, 1);
        @(posedge clk);
        #1;
        start1 = 0;
        for (int i = 0; i < 200 && beats1 < base + 20; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_reach", beats1 >= base + 20, 1);
        #2;
        reset_n = 0;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_addr", rom_addr1, 0);
        chk("abort_valid", valid1, 0);
        chk("abort_data", data1, 0);
        chk("abort_last", last1, 0);
        q1.delete();
        @(posedge clk);
        #1;
        chk("abort_hold_valid", valid1, 0);
        reset_n = 1;
        @(posedge clk);
        #1;
        run_row(0, 6'd2, 0, L0, 1, 69, 0);

        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
